raw_bitpack_32: RTL
===================

# raw_bitpack_32

Parametrised successor to the 10-bit raw packer. Converts the imager's 16-bit raw pixel/header stream into a 32-bit word stream. In tight-pack mode, pixels of any width from 8 to 16 bits are concatenated LSB-first with no padding inside a row. In unpacked mode, 16-bit samples are paired. Sits between the imager datapath and the 32-bit host/USB FIFO; row-end, frame and other dtypes pass through.

## Interface
- PIXEL_WIDTH, 10, significant pixel bits (8..16); only datai[PIXEL_WIDTH-1:0] is used in pack mode.
- ACC_WIDTH, 48, accumulator width; must be ≥ 31 + PIXEL_WIDTH.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- resetb  in  1  synchronous, active-low reset, sampled on rising clk.
- datai  in  16  raw pixel or header word.
- dvi  in  1  datai/dtypei valid this cycle.
- dtypei  in  `DTYPE_WIDTH  stream dtype (dtypes.v).
- image_type  in  16  replaces header word at index `Image_image_type.
- pack  in  1  1 = tight bit-pack, 0 = two 16-bit samples per word; only changes at frame boundaries.
- datao  out  32  output word.
- dvo  out  1  datao/dtypeo valid, one-cycle pulse per word.
- dtypeo  out  `DTYPE_WIDTH  output dtype.
- ovf  out  1  sticky; input arrived while a row-end emission was pending (input dropped).
- wcnt  out  16  pixel words emitted in last row (only with RAW_PACK_WCNT_EN, else tied 0).

## Operation
- **Reset.** resetb low at a clk edge sets:
  - datao, dvo, dtypeo, ovf, wcnt = 0;
  - accumulator acc = 0, fill = 0, hdr_idx = 0, half = 0, pend_re = 0.
- **Pixel, pack=1** (dtypei & `DTYPE_PIXEL_MASK nonzero):
  - acc |= datai[PIXEL_WIDTH-1:0] << fill; fill += PIXEL_WIDTH.
  - If the new fill ≥ 32: emit acc[31:0] with dtypeo = dtypei, then acc >>= 32 and fill -= 32.
- **Pixel, pack=0:**
  - First sample goes to datao[15:0] (half=1), no dvo.
  - Second sample goes to datao[31:16], dvo=1, half=0.
- **Header** (dtypei == `DTYPE_HEADER), packed two per word regardless of pack:
  - The word is image_type when hdr_idx == `Image_image_type, else datai.
  - hdr_idx increments per header word.
- **Row end / non-pixel, non-header dtypes.** hdr_idx resets to 0. Then:
  - Residue present (fill>0 or half=1): emit the residue zero-padded as dtypeo = `DTYPE_PIXEL` (or `DTYPE_HEADER` for a header half), set pend_re. Next cycle emit dtypeo = dtypei with datao = {16'b0, datai}. Clear acc/fill/half.
  - No residue: emit the pass-through word directly.
- **Pending row end** (pend_re=1): if dvi arrives in that cycle, it is dropped and ovf is set. Upstream guarantees ≥1 idle cycle after `DTYPE_ROW_END`.
- **Arithmetic.**
  - fill is 6 bits, max 31 + PIXEL_WIDTH ≤ 47.
  - Shifts are logical; the pad bits above fill are always 0.

## Timing
- All outputs registered; latency 1 cycle from the completing input beat to dvo.
- dvo asserts for exactly one cycle per word; no back-pressure (downstream FIFO must absorb the full rate).
- Row end with residue: residue word at N+1, row-end word at N+2. Without residue: row-end word at N+1.
- dvi=0 and no pending emission: dvo=0; datao/dtypeo hold.
- Reset mid-row discards the partial word; the first output after reset is from fresh input only.

## Configuration
- RAW_PACK_WCNT_EN defined:
  - A 16-bit counter increments on every emitted pixel-dtype word, including the flushed residue.
  - On the row-end emission it is copied to wcnt and cleared; wcnt holds until the next row end.
- Undefined: counter absent, wcnt = 0 constant.

## Test plan
- PIXEL_WIDTH=10, pack=1, 16 pixels 0x3FF then row end:
  - 5 words 0xFFFFFFFF, then row end on the next cycle (no residue word);
  - wcnt=5 with RAW_PACK_WCNT_EN.
- PIXEL_WIDTH=12, pack=1, pixels 0x001,0x002,0x003 then row end:
  - word0 = 0x03002001;
  - word1 = 0x00000000 residue (fill=4, value 0x0 from pixel 3's upper bits);
  - then row end; verify ovf stays 0.
- pack=0, pixels 0x0001, 0x0002, 0x0003 then row end:
  - 0x00020001;
  - then residue 0x00000003 as `DTYPE_PIXEL`;
  - then row end.
- Header words 0..7 = 0xAA00+i, image_type=0x1234: the word at index `Image_image_type reads 0x1234; 4 header words out.
- Row end followed by dvi in the next cycle with residue pending: the input is dropped, ovf=1 and sticky until reset.
- resetb low for one edge after 3 packed pixels, then 4 pixels of 0x3FF (W=8 effective, PIXEL_WIDTH=8): single word 0xFFFFFFFF; no stale bits.

Source files
------------

// File: rtl/raw_bitpack_32.sv
// rtl/raw_bitpack_32.sv - 16-bit raw pixel/header stream to 32-bit word packer (optional RAW_PACK_WCNT_EN)
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h01
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h01
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h02
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h04
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h08
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h10
`endif
`ifndef Image_image_type
`define Image_image_type 2
`endif

module raw_bitpack_32 #(
    parameter int PIXEL_WIDTH = 10,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic [15:0]             datai,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [15:0]             image_type,
    input  logic                    pack,
    output logic [31:0]             datao,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic                    ovf,
    output logic [15:0]             wcnt
);
    localparam int DW = `DTYPE_WIDTH;
    localparam logic [DW-1:0] T_PIXEL    = DW'(`DTYPE_PIXEL);
    localparam logic [DW-1:0] T_PIX_MASK = DW'(`DTYPE_PIXEL_MASK);
    localparam logic [DW-1:0] T_HEADER   = DW'(`DTYPE_HEADER);
    localparam logic [7:0]    HDR_IMG    = 8'(`Image_image_type);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [5:0]           r_fill;
    logic                 r_half;
    logic                 r_half_hdr;
    logic [15:0]          r_lo;
    logic [7:0]           r_hdr_idx;
    logic                 r_pend_re;
    logic [DW-1:0]        r_pend_dtype;
    logic [15:0]          r_pend_data;

    logic                 w_is_pix;
    logic                 w_is_hdr;
    logic [ACC_WIDTH-1:0] w_pix_ext;
    logic [ACC_WIDTH-1:0] w_acc_or;
    logic [5:0]           w_fill_add;
    logic [15:0]          w_hdr_word;

    // Classify the incoming beat and form the tight-pack accumulator update
    always_comb begin
        w_is_pix   = (dtypei & T_PIX_MASK) != '0;
        w_is_hdr   = (dtypei == T_HEADER);
        w_pix_ext  = '0;
        w_pix_ext[PIXEL_WIDTH-1:0] = datai[PIXEL_WIDTH-1:0];
        w_acc_or   = r_acc | (w_pix_ext << r_fill);
        w_fill_add = r_fill + 6'(PIXEL_WIDTH);
        w_hdr_word = (r_hdr_idx == HDR_IMG) ? image_type : datai;
    end

    // Packing state, output word register and the deferred row-end emission
    always_ff @(posedge clk) begin
        if (!resetb) begin
            datao        <= '0;
            dvo          <= 1'b0;
            dtypeo       <= '0;
            ovf          <= 1'b0;
            r_acc        <= '0;
            r_fill       <= '0;
            r_half       <= 1'b0;
            r_half_hdr   <= 1'b0;
            r_lo         <= '0;
            r_hdr_idx    <= '0;
            r_pend_re    <= 1'b0;
            r_pend_dtype <= '0;
            r_pend_data  <= '0;
        end else begin
            dvo <= 1'b0;
            if (r_pend_re) begin
                // the residue went out last cycle; now the row-end word itself
                dvo       <= 1'b1;
                datao     <= {16'h0000, r_pend_data};
                dtypeo    <= r_pend_dtype;
                r_pend_re <= 1'b0;
                if (dvi) begin
                    ovf <= 1'b1;
                end
            end else if (dvi) begin
                if (w_is_pix) begin
                    if (pack) begin
                        if (w_fill_add >= 6'd32) begin
                            dvo    <= 1'b1;
                            datao  <= w_acc_or[31:0];
                            dtypeo <= dtypei;
                            r_acc  <= w_acc_or >> 32;
                            r_fill <= w_fill_add - 6'd32;
                        end else begin
                            r_acc  <= w_acc_or;
                            r_fill <= w_fill_add;
                        end
                    end else if (r_half) begin
                        dvo    <= 1'b1;
                        datao  <= {datai, r_lo};
                        dtypeo <= dtypei;
                        r_half <= 1'b0;
                    end else begin
                        r_lo       <= datai;
                        r_half     <= 1'b1;
                        r_half_hdr <= 1'b0;
                    end
                end else if (w_is_hdr) begin
                    r_hdr_idx <= r_hdr_idx + 8'd1;
                    if (r_half) begin
                        dvo    <= 1'b1;
                        datao  <= {w_hdr_word, r_lo};
                        dtypeo <= T_HEADER;
                        r_half <= 1'b0;
                    end else begin
                        r_lo       <= w_hdr_word;
                        r_half     <= 1'b1;
                        r_half_hdr <= 1'b1;
                    end
                end else begin
                    r_hdr_idx <= '0;
                    r_acc     <= '0;
                    r_fill    <= '0;
                    r_half    <= 1'b0;
                    dvo       <= 1'b1;
                    if (r_fill != 6'd0) begin
                        datao        <= r_acc[31:0];
                        dtypeo       <= T_PIXEL;
                        r_pend_re    <= 1'b1;
                        r_pend_dtype <= dtypei;
                        r_pend_data  <= datai;
                    end else if (r_half) begin
                        datao        <= {16'h0000, r_lo};
                        dtypeo       <= r_half_hdr ? T_HEADER : T_PIXEL;
                        r_pend_re    <= 1'b1;
                        r_pend_dtype <= dtypei;
                        r_pend_data  <= datai;
                    end else begin
                        datao  <= {16'h0000, datai};
                        dtypeo <= dtypei;
                    end
                end
            end
        end
    end

`ifdef RAW_PACK_WCNT_EN
    logic [15:0] r_word_cnt;
    logic        w_cnt_inc;
    logic        w_cnt_latch;

    // Decide whether this cycle emits a pixel word or the row-end word
    always_comb begin
        w_cnt_inc   = 1'b0;
        w_cnt_latch = 1'b0;
        if (r_pend_re) begin
            w_cnt_latch = 1'b1;
        end else if (dvi) begin
            if (w_is_pix) begin
                w_cnt_inc = pack ? (w_fill_add >= 6'd32) : r_half;
            end else if (!w_is_hdr) begin
                if (r_fill != 6'd0 || (r_half && !r_half_hdr)) begin
                    w_cnt_inc = 1'b1;
                end else if (!r_half) begin
                    w_cnt_latch = 1'b1;
                end
            end
        end
    end

    // Count pixel words in the row and publish the total at row end
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_word_cnt <= '0;
            wcnt       <= '0;
        end else if (w_cnt_latch) begin
            wcnt       <= r_word_cnt;
            r_word_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end
`else
    assign wcnt = 16'h0000;
`endif

endmodule
